ex_div_sequencer: RTL and testbench

Multi-cycle 32-bit integer divider controller for the EX stage (DIV/DIVU).
- Captures operands when EX issues a start.
- Runs a radix-2 restoring division, one bit per cycle.
- Holds the pipeline through its stall request until the {remainder, quotient} result is ready for the HI/LO write path in EX.
- Honours an annul from the pipeline so a flushed instruction never completes.

---
 rtl/ex_div_sequencer_pkg.sv | 21 ++
 rtl/ex_div_sequencer_if.sv | 25 ++
 rtl/ex_div_sequencer_div_step.sv | 26 ++
 rtl/ex_div_sequencer.sv | 113 +++++++++++
 tb/tb_ex_div_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/ex_div_sequencer_pkg.sv
// Shared constants for the EX-stage divider: FSM state codes, result-ready
// flags and the start/stall handshake levels used across the pipeline.
package ex_div_sequencer_pkg;

   typedef logic [1:0] div_state_t;

   localparam div_state_t DivFree   = 2'b00;
   localparam div_state_t DivByZero = 2'b01;
   localparam div_state_t DivOn     = 2'b10;
   localparam div_state_t DivEnd    = 2'b11;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

endpackage

// File: rtl/ex_div_sequencer_if.sv
// Handshake bundle between the EX stage (master) and the divider (slave).
interface ex_div_sequencer_if #(
   parameter int DATA_W = 32
);

   logic                start;
   logic                signed_div;
   logic [DATA_W-1:0]   opdata1;
   logic [DATA_W-1:0]   opdata2;
   logic                annul;
   logic [2*DATA_W-1:0] result;
   logic                ready;
   logic                stallreq;

   modport master (
      output start, signed_div, opdata1, opdata2, annul,
      input  result, ready, stallreq
   );

   modport slave (
      input  start, signed_div, opdata1, opdata2, annul,
      output result, ready, stallreq
   );

endinterface

// File: rtl/ex_div_sequencer_div_step.sv
// One combinational radix-2 restoring division step on a packed {rem, quo}
// pair; kept standalone so a later MUL/DIV unit can reuse it.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [2*DATA_W-1:0] rem_quo,
   input  logic [DATA_W-1:0]   divisor,
   output logic [2*DATA_W-1:0] rem_quo_next
);

   logic [2*DATA_W:0] shifted;
   logic [DATA_W:0]   diff;

   // The extra top bit keeps the shifted remainder's carry, so the borrow
   // bit of diff is a reliable "shifted remainder < divisor" flag.
   always_comb begin
      shifted = {rem_quo, 1'b0};
      diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
      if (!diff[DATA_W]) begin
         rem_quo_next = {diff[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
      end else begin
         rem_quo_next = shifted[2*DATA_W-1:0];
      end
   end

endmodule

// File: rtl/ex_div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer for EX: latches operands on start, runs one
// restoring step per cycle and stalls the pipeline until the result is ready.
module ex_div_sequencer
   import ex_div_sequencer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input logic               clk,
   input logic               rst,
   ex_div_sequencer_if.slave bus
);

   div_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] dividend;
   logic [DATA_W-1:0]   divisor;
   logic                sign_q;
   logic                sign_r;
   logic [2*DATA_W-1:0] result_q;
   logic                ready_q;

   logic [2*DATA_W-1:0] step_next;
   logic [DATA_W-1:0]   op1_abs;
   logic [DATA_W-1:0]   op2_abs;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;
   logic                op1_neg;
   logic                op2_neg;
   logic                last_step;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem_quo      (dividend),
      .divisor      (divisor),
      .rem_quo_next (step_next)
   );

   // Signed operands are reduced to magnitudes; -2^(DATA_W-1) wraps onto
   // itself, which yields the natural overflow result without a special case.
   always_comb begin
      op1_neg   = bus.signed_div & bus.opdata1[DATA_W-1];
      op2_neg   = bus.signed_div & bus.opdata2[DATA_W-1];
      op1_abs   = op1_neg ? ({DATA_W{1'b0}} - bus.opdata1) : bus.opdata1;
      op2_abs   = op2_neg ? ({DATA_W{1'b0}} - bus.opdata2) : bus.opdata2;
      quo_fix   = sign_q ? ({DATA_W{1'b0}} - step_next[DATA_W-1:0])
                         : step_next[DATA_W-1:0];
      rem_fix   = sign_r ? ({DATA_W{1'b0}} - step_next[2*DATA_W-1:DATA_W])
                         : step_next[2*DATA_W-1:DATA_W];
      last_step = (cnt == CNT_W'(DATA_W - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= DivFree;
         cnt      <= '0;
         dividend <= '0;
         divisor  <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         result_q <= '0;
         ready_q  <= DivResultNotReady;
      end else begin
         case (state)
            DivFree: begin
               if (bus.start == DivStart && !bus.annul) begin
                  dividend <= {{DATA_W{1'b0}}, op1_abs};
                  divisor  <= op2_abs;
                  sign_q   <= op1_neg ^ op2_neg;
                  sign_r   <= op1_neg;
                  cnt      <= '0;
                  state    <= (bus.opdata2 == '0) ? DivByZero : DivOn;
               end
            end
            DivByZero: begin
               if (bus.annul) begin
                  state <= DivFree;
               end else begin
                  result_q <= '0;
                  ready_q  <= DivResultReady;
                  state    <= DivEnd;
               end
            end
            DivOn: begin
               if (bus.annul) begin
                  state <= DivFree;
               end else begin
                  dividend <= step_next;
                  cnt      <= cnt + 1'b1;
                  if (last_step) begin
                     result_q <= {rem_fix, quo_fix};
                     ready_q  <= DivResultReady;
                     state    <= DivEnd;
                  end
               end
            end
            DivEnd: begin
               if (bus.annul || bus.start == DivStop) begin
                  ready_q <= DivResultNotReady;
                  state   <= DivFree;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end

   // Stall is combinational so EX freezes in the very cycle it issues start.
   assign bus.stallreq = ((state == DivFree && bus.start && !bus.annul) ||
                          state == DivOn || state == DivByZero) ? Stop : NoStop;
   assign bus.result   = result_q;
   assign bus.ready    = ready_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Directed plus randomized bench for ex_div_sequencer, checked against a
// plain-arithmetic division model.
module tb_ex_div_sequencer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ex_div_sequencer_if #(.DATA_W(32)) dif ();

   ex_div_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [63:0] last_result = '0;

   // Quotient truncates toward zero, remainder takes the dividend's sign.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      int          sa;
      int          sb;
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) return 64'd0;
      if (!sgn) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      return {r, q};
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic s, input logic sd, input logic [31:0] a,
                                 input logic [31:0] b, input logic an);
      dif.start      = s;
      dif.signed_div = sd;
      dif.opdata1    = a;
      dif.opdata2    = b;
      dif.annul      = an;
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input string tag);
      logic [63:0] exp;
      int          lat;
      exp = ref_div(a, b, sgn);
      lat = (b == 32'd0) ? 2 : 33;
      @(negedge clk);
      apply_stimulus(1'b1, sgn, a, b, 1'b0);
      #1 check_output({tag, "_stall_T"}, 64'(dif.stallreq), 64'd1);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == lat - 1) begin
            check_output({tag, "_ready_early"}, 64'(dif.ready), 64'd0);
            check_output({tag, "_stall_busy"}, 64'(dif.stallreq), 64'd1);
         end
         if (c == 1) apply_stimulus(1'b1, 1'($urandom), $urandom, $urandom, 1'b0);
      end
      check_output({tag, "_ready"}, 64'(dif.ready), 64'd1);
      check_output({tag, "_stall_done"}, 64'(dif.stallreq), 64'd0);
      check_output({tag, "_result"}, dif.result, exp);
      apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check_output({tag, "_ready_drop"}, 64'(dif.ready), 64'd0);
      check_output({tag, "_stall_idle"}, 64'(dif.stallreq), 64'd0);
      last_result = exp;
   endtask

   initial begin
      logic        ready_seen;
      logic [31:0] ra;
      logic [31:0] rb;

      rst = 1'b0;
      apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      check_output("reset_ready", 64'(dif.ready), 64'd0);
      check_output("reset_result", dif.result, 64'd0);
      check_output("reset_stall", 64'(dif.stallreq), 64'd0);
      rst = 1'b1;

      $display("[TB] directed divisions");
      run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
      run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
      run_div(32'd5, 32'd0, 1'b0, "divu_by_zero");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow");
      run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");

      $display("[TB] start together with annul is ignored");
      @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 32'd9, 32'd3, 1'b1);
      #1 check_output("annul_start_stall", 64'(dif.stallreq), 64'd0);
      @(negedge clk);
      check_output("annul_start_stall_held", 64'(dif.stallreq), 64'd0);
      apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check_output("annul_start_ready", 64'(dif.ready), 64'd0);

      $display("[TB] annul mid-division");
      @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      repeat (10) @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b1);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #1 check_output("annul_on_stall", 64'(dif.stallreq), 64'd0);
      ready_seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (dif.ready) ready_seen = 1'b1;
      end
      check_output("annul_on_never_ready", 64'(ready_seen), 64'd0);
      check_output("annul_on_result_kept", dif.result, last_result);
      run_div(32'd9, 32'd3, 1'b0, "divu_9_3");

      $display("[TB] reset mid-division");
      @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      repeat (15) @(negedge clk);
      rst = 1'b0;
      apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      check_output("midreset_ready", 64'(dif.ready), 64'd0);
      check_output("midreset_result", dif.result, 64'd0);
      check_output("midreset_stall", 64'(dif.stallreq), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run_div(32'd1, 32'd1, 1'b0, "divu_1_1");

      $display("[TB] randomized divisions");
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         if (i % 6 == 0) rb = 32'd0;
         else if (i % 2 == 0) rb = $urandom;
         else rb = $urandom_range(1000, 1);
         run_div(ra, rb, 1'($urandom), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
